prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width; depth = 2**ADDR_W words.
REQ-002 Parameter DATA_W, fixed 16, instruction word width; other values are unsupported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte accepted on a cycle where in_valid and in_ready are both 1.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  word write address.
REQ-011 imem_wdata  output  16  word write data.
REQ-012 cpu_reset  output  1  active-high hold for the processor; 1 while not DONE.
REQ-013 done  output  1  image fully written; processor released.
REQ-014 error  output  1  image header exceeds depth; session aborted.

Function
REQ-015 Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words, each high byte first.
REQ-016 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
REQ-017 IDLE: in_ready=0; start -> LEN_HI, clears done, error and word counter, sets cpu_reset=1.
REQ-018 LEN_HI/LEN_LO/DATA_HI/DATA_LO: in_ready=1; each accepted byte advances one state; no byte is consumed without in_valid.
REQ-019 After LEN_LO: N=0 -> DONE; N>2**ADDR_W -> ERR; otherwise -> DATA_HI.
REQ-020 After DATA_LO accept -> WRITE; WRITE lasts exactly one cycle with imem_we=1, in_ready=0, imem_addr=word counter, imem_wdata={hi,lo}.
REQ-021 Write latency: imem_we asserts the cycle after the low byte is accepted.
REQ-022 After WRITE the counter increments; counter==N -> DONE, else -> DATA_HI.
REQ-023 Counter is ADDR_W+1 bits; N=2**ADDR_W writes addresses 0..2**ADDR_W-1 without wrap or overwrite.
REQ-024 DONE: done=1, cpu_reset=0, in_ready=0; holds until start.
REQ-025 ERR: error=1, cpu_reset=1, in_ready=0; holds until start.
REQ-026 start outside IDLE, DONE and ERR is ignored; no load is restarted mid-session.
REQ-027 start in DONE or ERR behaves as in IDLE (REQ-017), the same cycle.
REQ-028 imem_addr and imem_wdata are held stable outside WRITE; imem_we=0 outside WRITE.

Reset
REQ-029 Reset assertion forces, asynchronously: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, counter=0.
REQ-030 Reset mid-session abandons the session; a partially written image is not erased, and done stays 0 until a full new session completes.

Structure
REQ-031 The state encoding and the header byte-order constants are declared in the shared processor package.
REQ-032 Single module; no sub-module; it drives the processor's instruction-memory write port and the processor reset.

Verification
REQ-033 start; bytes 00 02 12 34 AB CD -> writes 0x1234@0 and 0xABCD@1; done=1 and cpu_reset=0 one cycle after the second write.
REQ-034 start; header 00 00 -> DONE the cycle after LEN_LO; imem_we never asserts.
REQ-035 ADDR_W=8; header 01 01 -> error=1, cpu_reset=1, no writes; a later start with a valid image completes normally.
REQ-036 Header 01 00 with 512 bytes and random in_valid gaps -> 256 writes at addresses 0..255 in order; no byte lost or duplicated.
REQ-037 Reset asserted after 3 of 5 words -> all outputs at reset values immediately; start pulses in LEN_LO are ignored.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-image loader: FSM state encoding and the
// byte order of the length header and the instruction words in the stream.
package prog_loader_pkg;

    // Width of one stream element and of one assembled instruction word.
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // Width of the word-count header that opens every image.
    localparam int LEN_W = 16;

    // Big-endian pairs: the first byte received lands in the upper half.
    localparam int HI_BYTE_LSB = 8;
    localparam int LO_BYTE_LSB = 0;

    // Loader FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    // Join a high/low byte pair into a word using the stream byte order.
    function automatic logic [WORD_W-1:0] join_be(input logic [BYTE_W-1:0] first_byte,
                                                  input logic [BYTE_W-1:0] second_byte);
        logic [WORD_W-1:0] word;
        word = '0;
        word[HI_BYTE_LSB +: BYTE_W] = first_byte;
        word[LO_BYTE_LSB +: BYTE_W] = second_byte;
        return word;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-image loader: accepts a length-prefixed byte stream, writes the
// assembled 16-bit words into instruction memory and holds the processor in
// reset until the complete image has been written.
// ADDR_W is expected in the range 1..16 (the header can count at most 65535 words).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // Memory depth expressed at header width plus one, so 2**16 still fits.
    localparam logic [LEN_W:0] DEPTH = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_t            state_reg;
    logic [ADDR_W:0]   counter_reg;   // words written so far; one extra bit so a full memory is countable
    logic [ADDR_W:0]   len_reg;       // validated word count for the running session
    logic [BYTE_W-1:0] len_hi_reg;    // upper header byte, waiting for its partner
    logic [BYTE_W-1:0] data_hi_reg;   // upper instruction byte, waiting for its partner

    logic [LEN_W-1:0]  header_len;
    logic [LEN_W:0]    header_len_ext;
    logic              header_zero;
    logic              header_too_big;
    logic [ADDR_W:0]   counter_inc;
    logic              accept;
    logic              session_done;

    // Header decode uses the live low byte so the length decision is made on the accepting edge.
    assign header_len     = join_be(len_hi_reg, in_data);
    assign header_len_ext = {1'b0, header_len};
    assign header_zero    = (header_len == '0);
    assign header_too_big = (header_len_ext > DEPTH);
    assign counter_inc    = counter_reg + {{ADDR_W{1'b0}}, 1'b1};
    assign accept         = in_valid && in_ready;
    assign session_done   = (counter_inc == len_reg);

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            len_reg     <= '0;
            len_hi_reg  <= '0;
            data_hi_reg <= '0;
            in_ready    <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse; address and data simply hold.
            imem_we <= 1'b0;

            case (state_reg)
                // Idle and both terminal states react only to start; the outcome flags hold otherwise.
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_reg   <= LEN_HI;
                        counter_reg <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        cpu_reset   <= 1'b1;
                        in_ready    <= 1'b1;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        len_hi_reg <= in_data;
                        state_reg  <= LEN_LO;
                    end
                end

                // The full header is known here: empty image, oversize image or payload.
                LEN_LO: begin
                    if (accept) begin
                        if (header_zero) begin
                            state_reg <= DONE;
                            in_ready  <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else if (header_too_big) begin
                            state_reg <= ERR;
                            in_ready  <= 1'b0;
                            error     <= 1'b1;
                        end else begin
                            len_reg   <= header_len_ext[ADDR_W:0];
                            state_reg <= DATA_HI;
                        end
                    end
                end

                DATA_HI: begin
                    if (accept) begin
                        data_hi_reg <= in_data;
                        state_reg   <= DATA_LO;
                    end
                end

                // Low byte completes the word; the write strobe fires on the next cycle.
                DATA_LO: begin
                    if (accept) begin
                        state_reg  <= WRITE;
                        in_ready   <= 1'b0;
                        imem_we    <= 1'b1;
                        imem_addr  <= counter_reg[ADDR_W-1:0];
                        imem_wdata <= join_be(data_hi_reg, in_data);
                    end
                end

                // One-cycle write slot; count the word and decide whether the image is complete.
                WRITE: begin
                    counter_reg <= counter_inc;
                    if (session_done) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state_reg <= DATA_HI;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b0;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives length-prefixed images, predicts
// every memory write in a scoreboard queue and checks the control outputs.
module tb_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Expected writes in order: {address, word}.
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] mon_entry;
    int write_count    = 0;
    int last_write_cyc = -100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write monitor: every strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                fail_cnt++;
                $error("FAIL spurious_write: observed addr %0h data %0h expected no write", imem_addr, imem_wdata);
            end else begin
                mon_entry = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(mon_entry[ADDR_W+DATA_W-1:DATA_W]));
                check("write_data", 32'(imem_wdata), 32'(mon_entry[DATA_W-1:0]));
            end
            $display("write addr=%02h data=%04h cycle=%0d", imem_addr, imem_wdata, cyc);
            write_count++;
            last_write_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one byte (after an optional random idle gap) until the DUT accepts it.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total_cnt++;
        fail_cnt++;
        $error("FAIL byte_accept_timeout: observed in_ready=%b expected 1 within 50 cycles", in_ready);
    endtask

    task automatic send_word(input logic [15:0] w, input int max_gap);
        send_byte(w[15:8], max_gap);
        send_byte(w[7:0], max_gap);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, 32'(done), 32'h1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'h0);
        check({tag, "_imem_we"},    32'(imem_we),    32'h0);
        check({tag, "_imem_addr"},  32'(imem_addr),  32'h0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'h0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'h1);
        check({tag, "_done"},       32'(done),       32'h0);
        check({tag, "_error"},      32'(error),      32'h0);
    endtask

    initial begin
        int wc0;
        logic [15:0] w;

        // Power-on reset values.
        tick(3);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);

        // Two-word image with completion latency.
        wc0 = write_count;
        pulse_start();
        @(negedge clk);
        check("a_ready_after_start", 32'(in_ready), 32'h1);
        check("a_cpu_reset_loading", 32'(cpu_reset), 32'h1);
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        @(posedge clk);
        #1;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        wait_done("a");
        check("a_done_latency", 32'(cyc - last_write_cyc), 32'h1);
        check("a_cpu_released", 32'(cpu_reset), 32'h0);
        check("a_ready_in_done", 32'(in_ready), 32'h0);
        check("a_addr_held", 32'(imem_addr), 32'h01);
        check("a_wdata_held", 32'(imem_wdata), 32'hABCD);
        check("a_write_count", 32'(write_count - wc0), 32'h2);
        tick(3);
        check("a_done_holds", 32'(done), 32'h1);

        // Empty image: straight to DONE, no writes.
        wc0 = write_count;
        pulse_start();
        @(negedge clk);
        check("b_done_cleared", 32'(done), 32'h0);
        check("b_cpu_reset_reasserted", 32'(cpu_reset), 32'h1);
        @(posedge clk);
        #1;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("b_done_after_len_lo", 32'(done), 32'h1);
        check("b_cpu_released", 32'(cpu_reset), 32'h0);
        tick(4);
        check("b_no_writes", 32'(write_count - wc0), 32'h0);

        // Oversize header (257 words) aborts, then a normal image recovers.
        wc0 = write_count;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check("c_error", 32'(error), 32'h1);
        check("c_cpu_reset_held", 32'(cpu_reset), 32'h1);
        check("c_not_done", 32'(done), 32'h0);
        check("c_ready_in_err", 32'(in_ready), 32'h0);
        tick(5);
        check("c_error_holds", 32'(error), 32'h1);
        check("c_no_writes", 32'(write_count - wc0), 32'h0);
        pulse_start();
        @(negedge clk);
        check("c_error_cleared", 32'(error), 32'h0);
        @(posedge clk);
        #1;
        exp_q.push_back({8'h00, 16'h5AA5});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(16'h5AA5, 0);
        wait_done("c_recover");
        check("c_recover_error", 32'(error), 32'h0);

        // Full-depth image with random stream gaps.
        wc0 = write_count;
        pulse_start();
        send_byte(8'h01, 2);
        send_byte(8'h00, 2);
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            exp_q.push_back({8'(i), w});
            send_word(w, 2);
        end
        wait_done("d");
        check("d_write_count", 32'(write_count - wc0), 32'd256);
        check("d_queue_drained", 32'(exp_q.size()), 32'h0);
        check("d_last_addr", 32'(imem_addr), 32'hFF);

        // Ignored starts mid-session, then reset after 3 of 5 words.
        wc0 = write_count;
        pulse_start();
        send_byte(8'h00, 0);
        pulse_start();
        @(negedge clk);
        check("e_ready_after_ignored_start", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        send_byte(8'h05, 0);
        exp_q.push_back({8'h00, 16'h1111});
        exp_q.push_back({8'h01, 16'h2222});
        exp_q.push_back({8'h02, 16'h3333});
        send_word(16'h1111, 0);
        pulse_start();
        send_word(16'h2222, 0);
        send_word(16'h3333, 0);
        @(posedge clk);
        #1;
        check("e_three_writes", 32'(write_count - wc0), 32'h3);
        check("e_queue_drained", 32'(exp_q.size()), 32'h0);
        check("e_ready_mid_session", 32'(in_ready), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("e_async_reset");
        tick(2);
        reset = 1'b1;
        tick(3);
        check("e_idle_not_done", 32'(done), 32'h0);
        check("e_idle_ready", 32'(in_ready), 32'h0);
        pulse_start();
        exp_q.push_back({8'h00, 16'hBEEF});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(16'hBEEF, 0);
        wait_done("e_new_session");
        check("e_final_queue", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
